// File: rtl/coremem_pkg.sv
// Shared types for the core-to-SRAM bridge: response-pipe entry and response codes.
// No logic; latency and backpressure are defined by the modules that import it.
package coremem_pkg;

    typedef struct packed {
        logic valid;
        logic is_read;
        logic err;
    } resp_t;

    localparam resp_t RESP_RST    = '0;
    localparam logic  RESP_OKAY   = 1'b0;
    localparam logic  RESP_SLVERR = 1'b1;

endpackage

// File: rtl/coremem_resp_pipe.sv
// DEPTH-stage shift register of response descriptors; latency DEPTH cycles.
// No backpressure: one entry in, one entry out per cycle; async reset empties it.
module coremem_resp_pipe
    import coremem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  resp_t in_dat,
    output resp_t out_dat
);

    resp_t stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESP_RST;
            end
        end else begin
            stage_q[0] <= in_dat;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_dat = stage_q[DEPTH-1];

endmodule

// File: rtl/coremem_pipe.sv
// Core data port to synchronous SRAM bridge; responses exactly RD_LATENCY cycles after grant, in order.
// Grant is req & ~mem_busy_i in the same cycle; no wait states, responses are never stalled.
module coremem_pipe
    import coremem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 4096,
    parameter int RD_LATENCY = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         data_req_i,
    output logic                         data_gnt_o,
    input  logic                         data_we_i,
    input  logic [DATA_WIDTH/8-1:0]      data_be_i,
    input  logic [ADDR_WIDTH-1:0]        data_addr_i,
    input  logic [DATA_WIDTH-1:0]        data_wdata_i,
    output logic                         data_rvalid_o,
    output logic [DATA_WIDTH-1:0]        data_rdata_o,
    output logic                         data_err_o,
    input  logic                         mem_busy_i,
    output logic                         CE,
    output logic                         WE,
    output logic [$clog2(MEM_WORDS)-1:0] A,
    output logic [DATA_WIDTH/8-1:0]      BE,
    output logic [DATA_WIDTH-1:0]        D,
    input  logic [DATA_WIDTH-1:0]        Q
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int OFF_W = $clog2(BE_W);

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("coremem_pipe: RD_LATENCY must be 1..4");
    end
    if (DATA_WIDTH < 8 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_width
        $error("coremem_pipe: DATA_WIDTH must be a power of two >= 8");
    end

    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  in_range;
    resp_t                 resp_in;
    resp_t                 resp_out;

    assign word_idx   = data_addr_i >> OFF_W;
    assign in_range   = (word_idx < ADDR_WIDTH'(MEM_WORDS));
    assign data_gnt_o = data_req_i & ~mem_busy_i;

    // Out-of-range requests are granted but never reach the macro.
    assign CE = data_gnt_o & in_range;
    assign WE = CE & data_we_i;
    assign A  = word_idx[IDX_W-1:0];
    assign BE = data_be_i & {BE_W{WE}};
    assign D  = data_wdata_i;

    always_comb begin
        resp_in = RESP_RST;
        if (data_gnt_o) begin
            resp_in.valid   = 1'b1;
            resp_in.is_read = ~data_we_i;
            resp_in.err     = in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

    coremem_resp_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_resp_pipe (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .in_dat  (resp_in),
        .out_dat (resp_out)
    );

    assign data_rvalid_o = resp_out.valid;
    assign data_err_o    = resp_out.err;
    assign data_rdata_o  = (resp_out.valid & resp_out.is_read & ~resp_out.err) ? Q : '0;

endmodule
